// File: rtl/calc_input_sequencer.sv
// -----------------------------------------------------------------------------
// calc_input_sequencer
//
// Front-end control stage of the calculator. Two raw push-buttons are brought
// into the clock domain, debounced, and turned into single-cycle press pulses.
// The advance pulse walks a 2-bit entry state through operand A, operand B,
// operator and result display. One-hot capture strobes tell the downstream
// registers which of them should latch the switches on this press.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced level
//                    changes (minimum 2)
//
// Ports
//   clk           in   system clock, rising-edge active
//   reset         in   synchronous, active-high reset
//   btnr          in   raw asynchronous advance button
//   btnl          in   raw asynchronous clear button
//   state         out  entry state: 00 A, 01 B, 10 operator, 11 result
//   press_pulse   out  one-cycle pulse per debounced btnr press
//   clear_pulse   out  one-cycle pulse per debounced btnl press
//   cap_a         out  capture strobe for operand A
//   cap_b         out  capture strobe for operand B
//   cap_op        out  capture strobe for the operator
//   result_valid  out  high while state is SHOW_RESULT
// -----------------------------------------------------------------------------
module calc_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnr,
  input  logic       btnl,
  output logic [1:0] state,
  output logic       press_pulse,
  output logic       clear_pulse,
  output logic       cap_a,
  output logic       cap_b,
  output logic       cap_op,
  output logic       result_valid
);

  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ENTER_A     = 2'b00,
    ENTER_B     = 2'b01,
    ENTER_OP    = 2'b10,
    SHOW_RESULT = 2'b11
  } state_t;

  // Bit 0 carries btnr, bit 1 carries btnl through the whole input path.
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       lvl_r;
  logic [1:0]       lvl_prev_r;
  logic [CNT_W-1:0] cnt_r [2];
  state_t           state_r;
  logic             cap_a_s;
  logic             cap_b_s;
  logic             cap_op_s;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {btnl, btnr};
      sync2_r <= sync1_r;
    end
  end

  // Debounce counters: the level only moves after DEBOUNCE_CYCLES
  // consecutive edges that disagree with it; any agreeing edge restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == lvl_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_MAX) begin
          lvl_r[i] <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising-edge detect on the debounced levels; releases produce nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_prev_r  <= 2'b00;
      press_pulse <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      lvl_prev_r  <= lvl_r;
      press_pulse <= lvl_r[0] & ~lvl_prev_r[0];
      clear_pulse <= lvl_r[1] & ~lvl_prev_r[1];
    end
  end

  // Entry-state FSM; clear has priority over advance. result_valid is
  // registered alongside the state so it tracks SHOW_RESULT exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ENTER_A;
      result_valid <= 1'b0;
    end else if (clear_pulse) begin
      state_r      <= ENTER_A;
      result_valid <= 1'b0;
    end else if (press_pulse) begin
      case (state_r)
        ENTER_A: begin
          state_r      <= ENTER_B;
          result_valid <= 1'b0;
        end
        ENTER_B: begin
          state_r      <= ENTER_OP;
          result_valid <= 1'b0;
        end
        ENTER_OP: begin
          state_r      <= SHOW_RESULT;
          result_valid <= 1'b1;
        end
        SHOW_RESULT: begin
          state_r      <= ENTER_A;
          result_valid <= 1'b0;
        end
        default: begin
          state_r      <= ENTER_A;
          result_valid <= 1'b0;
        end
      endcase
    end else begin
      state_r      <= state_r;
      result_valid <= (state_r == SHOW_RESULT);
    end
  end

  // Capture strobes decode the pre-press state during the pulse cycle, so
  // the downstream register latches on the same edge the state advances.
  always_comb begin
    cap_a_s  = 1'b0;
    cap_b_s  = 1'b0;
    cap_op_s = 1'b0;
    if (press_pulse && !clear_pulse) begin
      case (state_r)
        ENTER_A:     cap_a_s  = 1'b1;
        ENTER_B:     cap_b_s  = 1'b1;
        ENTER_OP:    cap_op_s = 1'b1;
        SHOW_RESULT: cap_a_s  = 1'b0;
        default:     cap_a_s  = 1'b0;
      endcase
    end else begin
      cap_a_s  = 1'b0;
      cap_b_s  = 1'b0;
      cap_op_s = 1'b0;
    end
  end

  assign state  = state_r;
  assign cap_a  = cap_a_s;
  assign cap_b  = cap_b_s;
  assign cap_op = cap_op_s;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for calc_input_sequencer with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, so every check sees the values produced by the preceding edge.
// Edge 0 is the first edge that samples a newly driven button level.
// -----------------------------------------------------------------------------
module tb_calc_input_sequencer;

  logic       clk;
  logic       reset;
  logic       btnr;
  logic       btnl;
  logic [1:0] state;
  logic       press_pulse;
  logic       clear_pulse;
  logic       cap_a;
  logic       cap_b;
  logic       cap_op;
  logic       result_valid;

  int tests_run;
  int tests_failed;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .btnr         (btnr),
    .btnl         (btnl),
    .state        (state),
    .press_pulse  (press_pulse),
    .clear_pulse  (clear_pulse),
    .cap_a        (cap_a),
    .cap_b        (cap_b),
    .cap_op       (cap_op),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clean btnr press from state st: pulse must land on edge 6, with the
  // strobe for st, then the state must step on edge 7. Release is debounced.
  task automatic do_press(input logic [1:0] st);
    int         n;
    int         extra;
    logic [1:0] nx;
    nx    = st + 2'd1;
    n     = 0;
    extra = 0;
    btnr  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_pulse === 1'b1 && n == 0) begin
        n = k;
        chk("press_state", {6'd0, state}, {6'd0, st});
        chk("press_cap_a", {7'd0, cap_a}, {7'd0, st == 2'b00});
        chk("press_cap_b", {7'd0, cap_b}, {7'd0, st == 2'b01});
        chk("press_cap_op", {7'd0, cap_op}, {7'd0, st == 2'b10});
        chk("press_rv", {7'd0, result_valid}, {7'd0, st == 2'b11});
        tick();
        chk("press_next_state", {6'd0, state}, {6'd0, nx});
        chk("press_next_rv", {7'd0, result_valid}, {7'd0, nx == 2'b11});
        break;
      end
    end
    chk("press_latency", 8'(n), 8'd7);
    btnr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (press_pulse !== 1'b0) extra++;
    end
    chk("release_no_pulse", 8'(extra), 8'd0);
  endtask

  initial begin
    int         extra;
    logic [16:0] bouncy;
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    btnr  = 1'b0;
    btnl  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_press", {7'd0, press_pulse}, 8'd0);
    chk("rst_clear", {7'd0, clear_pulse}, 8'd0);
    chk("rst_caps", {5'd0, cap_a, cap_b, cap_op}, 8'd0);
    chk("rst_rv", {7'd0, result_valid}, 8'd0);

    // Clean press held 20 cycles
    btnr  = 1'b1;
    extra = 0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (press_pulse !== 1'b0 || state !== 2'b00) extra++;
    end
    chk("t1_quiet_before", 8'(extra), 8'd0);
    tick();
    chk("t1_pulse_e6", {7'd0, press_pulse}, 8'd1);
    chk("t1_cap_a_e6", {7'd0, cap_a}, 8'd1);
    chk("t1_state_e6", {6'd0, state}, 8'd0);
    tick();
    chk("t1_pulse_e7", {7'd0, press_pulse}, 8'd0);
    chk("t1_state_e7", {6'd0, state}, 8'd1);
    extra = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (press_pulse !== 1'b0) extra++;
    end
    chk("t1_held_no_pulse", 8'(extra), 8'd0);
    btnr  = 1'b0;
    extra = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (press_pulse !== 1'b0) extra++;
    end
    chk("t1_release_no_pulse", 8'(extra), 8'd0);

    // Four clean presses from ENTER_A: cap_a, cap_b, cap_op, none
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t2_rst_state", {6'd0, state}, 8'd0);
    do_press(2'b00);
    do_press(2'b01);
    do_press(2'b10);
    do_press(2'b11);

    // Bouncy press: samples at edges 0..16, last rising sample at edge 7,
    // so the single pulse belongs on edge 13
    bouncy = 17'b1111111111_0_11_0_111;
    extra  = 0;
    for (int e = 0; e <= 16; e++) begin
      btnr = bouncy[e];
      tick();
      if (e == 13) begin
        chk("t3_bounce_pulse", {7'd0, press_pulse}, 8'd1);
        chk("t3_bounce_cap_a", {7'd0, cap_a}, 8'd1);
      end else if (press_pulse !== 1'b0) begin
        extra++;
      end else begin
        extra = extra;
      end
    end
    chk("t3_bounce_single", 8'(extra), 8'd0);
    chk("t3_bounce_state", {6'd0, state}, 8'd1);
    btnr = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    extra = 0;
    for (int e = 0; e < 12; e++) begin
      btnr = (e < 3) ? 1'b1 : 1'b0;
      tick();
      if (press_pulse !== 1'b0) extra++;
    end
    chk("t3_glitch_no_pulse", 8'(extra), 8'd0);
    chk("t3_glitch_state", {6'd0, state}, 8'd1);

    // Clear from ENTER_OP
    do_press(2'b01);
    btnl = 1'b1;
    for (int e = 0; e <= 5; e++) tick();
    chk("t4_clear_early", {7'd0, clear_pulse}, 8'd0);
    tick();
    chk("t4_clear_pulse", {7'd0, clear_pulse}, 8'd1);
    chk("t4_clear_caps", {5'd0, cap_a, cap_b, cap_op}, 8'd0);
    chk("t4_clear_state_hold", {6'd0, state}, 8'd2);
    tick();
    chk("t4_clear_pulse_end", {7'd0, clear_pulse}, 8'd0);
    chk("t4_clear_state", {6'd0, state}, 8'd0);
    btnl = 1'b0;
    for (int e = 0; e < 8; e++) tick();

    // Simultaneous press and clear from ENTER_B
    do_press(2'b00);
    btnr = 1'b1;
    btnl = 1'b1;
    for (int e = 0; e <= 6; e++) tick();
    chk("t5_both_press", {7'd0, press_pulse}, 8'd1);
    chk("t5_both_clear", {7'd0, clear_pulse}, 8'd1);
    chk("t5_both_caps", {5'd0, cap_a, cap_b, cap_op}, 8'd0);
    tick();
    chk("t5_both_state", {6'd0, state}, 8'd0);
    btnr = 1'b0;
    btnl = 1'b0;
    for (int e = 0; e < 8; e++) tick();

    // Reset with the btnr counter at 2, button held throughout
    do_press(2'b00);
    btnr = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_state", {6'd0, state}, 8'd0);
    chk("t6_rst_pulses", {6'd0, press_pulse, clear_pulse}, 8'd0);
    extra = 0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (press_pulse !== 1'b0) extra++;
    end
    chk("t6_no_early_pulse", 8'(extra), 8'd0);
    tick();
    chk("t6_pulse_e6", {7'd0, press_pulse}, 8'd1);
    chk("t6_cap_a_e6", {7'd0, cap_a}, 8'd1);
    tick();
    chk("t6_state_e7", {6'd0, state}, 8'd1);
    btnr = 1'b0;
    for (int e = 0; e < 8; e++) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
# calc_input_sequencer

Front-end control stage of the calculator. It synchronizes and debounces the raw right (advance) and left (clear) push-buttons. It steps the 2-bit entry state that the operand and operator capture registers downstream compare against. It also emits one-cycle, one-hot capture strobes so each downstream register latches the switches exactly once per physical press.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz); legal minimum 2.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btnr  in  1  raw, asynchronous advance button.
- btnl  in  1  raw, asynchronous clear button.
- state  out  2  current entry state: 00 ENTER_A, 01 ENTER_B, 10 ENTER_OP, 11 SHOW_RESULT.
- press_pulse  out  1  one-cycle pulse per debounced btnr press.
- clear_pulse  out  1  one-cycle pulse per debounced btnl press.
- cap_a  out  1  capture strobe for operand A.
- cap_b  out  1  capture strobe for operand B.
- cap_op  out  1  capture strobe for the operator.
- result_valid  out  1  high while state == SHOW_RESULT.

## Operation
- Per button: 2-flop synchronizer, then a debounce counter of width clog2(DEBOUNCE_CYCLES).
- Counter is cleared on every edge where the synchronized value equals the debounced level.
- Counter increments while the synchronized value differs from the debounced level.
- The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing edge. The counter clears at the same edge.
- Any bounce back to the current level restarts the count. A pulse shorter than DEBOUNCE_CYCLES never changes the level.
- The debounced level's previous value is registered. A 0→1 transition sets press_pulse (btnr) or clear_pulse (btnl) high for exactly one cycle.
- Release (1→0) generates no pulse.
- Capture strobes are combinational from the registered pulse and the current state:
  - cap_a = press_pulse & state==00.
  - cap_b = press_pulse & state==01.
  - cap_op = press_pulse & state==10.
  - No strobe fires in state 11.
- State FSM is updated on the edge that ends a pulse cycle:
  - press_pulse: 00→01→10→11→00 (wrap). Pressing in SHOW_RESULT returns to ENTER_A with no strobe.
  - clear_pulse: state → 00 from any state.
  - clear_pulse and press_pulse in the same cycle: clear wins. State → 00, and cap_a/cap_b/cap_op are forced low that cycle.
- result_valid = (state == 11).
- Reset (synchronous, highest priority) clears:
  - synchronizer flops, counters and debounced levels to 0;
  - state to 00;
  - press_pulse and clear_pulse to 0, so all strobes are 0.
- Reset mid-count discards the partial count.
- A button held through reset release registers as a press DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Timing
- Edge 0 is the first edge sampling raw btnr high; btnr is held stable.
  - Synchronized value is high after edge 1.
  - Debounced level rises at edge DEBOUNCE_CYCLES+1.
  - press_pulse is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
  - state advances at edge DEBOUNCE_CYCLES+3.
- During the pulse cycle, state still shows the pre-press value. The cap_* strobe for that value is high, so downstream registers latch at edge DEBOUNCE_CYCLES+3.
- Maximum one press_pulse per debounced press. Minimum spacing between pulses is 2*DEBOUNCE_CYCLES cycles: a full release must also be debounced.
- btnl has identical latency to btnr.
- All outputs are glitch-free registered values, except the cap_* strobes: one AND level after registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then clean btnr press held 20 cycles -> state 00 until press_pulse; press_pulse high exactly 1 cycle, starting at edge 6 after the first sample; cap_a high in that same cycle; state=01 at edge 7; no further pulse while held.
- Four clean presses with full releases between them -> strobes in order cap_a, cap_b, cap_op, then none; state sequence 00,01,10,11,00; result_valid high only in 11.
- Bouncy btnr (high 3 cycles, low 1, high 2, low 1, then high 10) -> exactly one press_pulse, which fires 6 edges after the final rising sample; a 3-cycle-only glitch yields no pulse.
- In state 10, press btnl -> clear_pulse for 1 cycle; state=00 next edge; no cap_* strobe.
- Drive btnr and btnl rising on the same edge from state 01 -> pulses coincide; state=00; cap_b stays low.
- Assert reset for 1 cycle while the btnr debounce counter is at 2, with btnr held high -> state=00 and all pulses 0 after reset; press_pulse appears 6 edges after reset deasserts; state=01 one edge later.
